// File: rtl/inst_fetch_axi_bridge_pkg.sv
// inst_fetch_axi_bridge_pkg: AXI4-Lite response codes, protection value and fetch FSM encoding
package inst_fetch_axi_bridge_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [2:0] ARPROT_INST = 3'b100;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/inst_fetch_axi_bridge.sv
// inst_fetch_axi_bridge: single-outstanding AXI4-Lite read master feeding the core instruction port
module inst_fetch_axi_bridge
   import inst_fetch_axi_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [2:0] ARPROT_VAL = ARPROT_INST
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  err_o,
   output logic                  stall_o,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [2:0]            m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready
);
   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    err_q;
   logic                    hit;

   // A result is only delivered when the core still asks for the address that was fetched;
   // otherwise (redirect or dropped request) it is silently discarded and the core stays stalled.
   assign hit      = (state == ST_DONE) && (addr_i == addr_q);
   assign stall_o  = req_i & ~hit;
   assign rvalid_o = req_i & hit;
   assign err_o    = rvalid_o & err_q;
   assign rdata_o  = (rvalid_o && !err_q) ? data_q : '0;
   assign m_araddr = addr_q;
   assign m_arprot = ARPROT_VAL;

   // Fetch FSM: latch PC, run AR then R handshakes, present the result for one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         m_arvalid <= 1'b0;
         m_rready  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (req_i) begin
               addr_q    <= addr_i;
               m_arvalid <= 1'b1;
               state     <= ST_AR;
            end
            ST_AR: if (m_arready) begin
               m_arvalid <= 1'b0;
               m_rready  <= 1'b1;
               state     <= ST_R;
            end
            ST_R: if (m_rvalid) begin
               data_q   <= m_rdata;
               err_q    <= m_rresp != RESP_OKAY;
               m_rready <= 1'b0;
               state    <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetch_axi_bridge.sv
// tb_inst_fetch_axi_bridge: scenario tasks plus a scoreboard checking every delivered fetch
module tb_inst_fetch_axi_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic [31:0] addr_i;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        err_o;
   logic        stall_o;
   logic [31:0] m_araddr;
   logic [2:0]  m_arprot;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid;
   logic        m_rready;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad = 0;
   int ar_delay = 0;
   int r_delay = 0;
   int ar_cnt = 0;
   int r_cnt = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;

   inst_fetch_axi_bridge dut (
      .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i),
      .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o), .stall_o(stall_o),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h4) ? 32'h3401_1100 : {a[15:0], ~a[15:0]};
   endfunction

   // slave: programmable AR/R wait states, SLVERR at 0x100
   always @(negedge clk) begin
      if (!rst) begin
         m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
         pend = 1'b0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (m_arready) begin
            m_arready = 1'b0; pend = 1'b1; r_cnt = 0;
         end else if (m_arvalid && !pend) begin
            if (ar_cnt >= ar_delay) begin
               m_arready = 1'b1; pend_addr = m_araddr; ar_cnt = 0;
            end else ar_cnt++;
         end
         if (m_rvalid) begin
            m_rvalid = 1'b0; pend = 1'b0;
         end else if (pend && m_rready) begin
            if (r_cnt >= r_delay) begin
               m_rvalid = 1'b1;
               m_rdata  = mem(pend_addr);
               m_rresp  = (pend_addr == 32'h100) ? 2'b10 : 2'b00;
            end else r_cnt++;
         end
      end
   end

   // scoreboard: each delivered fetch must match the oldest expectation
   always @(negedge clk) begin
      if (rst && rvalid_o) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected rdata_o=%h", rdata_o);
         end else begin
            exp_t x;
            x = sb.pop_front();
            if (rdata_o !== x.d || err_o !== x.e) begin
               bad++;
               $display("FAIL sb_data got %h/%b want %h/%b", rdata_o, err_o, x.d, x.e);
            end
         end
      end
   end

   task automatic test_reset;
      @(negedge clk);
      total++;
      if ({m_arvalid, m_rready, rvalid_o, err_o} !== 4'b0 || m_araddr !== 32'h0 || rdata_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_outs got arv=%b rr=%b rv=%b err=%b ara=%h rd=%h want zeros",
                  m_arvalid, m_rready, rvalid_o, err_o, m_araddr, rdata_o);
      end
      total++;
      if (m_arprot !== 3'b100) begin bad++; $display("FAIL reset_arprot got %b want 100", m_arprot); end
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall0 got %b want 0", stall_o); end
      req_i = 1'b1;
      #1;
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL reset_stall1 got %b want 1", stall_o); end
      req_i = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_zero_wait;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req_i = 1'b1; addr_i = 32'h4; sb.push_back('{32'h3401_1100, 1'b0});
         end
         @(negedge clk);
         total++;
         if (stall_o !== (c < 3)) begin bad++; $display("FAIL zw_stall c=%0d got %b want %b", c, stall_o, c < 3); end
         total++;
         if (m_arvalid !== (c == 1)) begin bad++; $display("FAIL zw_arvalid c=%0d got %b want %b", c, m_arvalid, c == 1); end
         total++;
         if (m_rready !== (c == 2)) begin bad++; $display("FAIL zw_rready c=%0d got %b want %b", c, m_rready, c == 2); end
         total++;
         if (rvalid_o !== (c == 3)) begin bad++; $display("FAIL zw_rvalid c=%0d got %b want %b", c, rvalid_o, c == 3); end
         if (c == 1) begin
            total++;
            if (m_araddr !== 32'h4) begin bad++; $display("FAIL zw_araddr got %h want 00000004", m_araddr); end
         end
      end
      @(posedge clk); #1 req_i = 1'b0;
   endtask

   task automatic test_backpressure;
      ar_delay = 3; r_delay = 2;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req_i = 1'b1; addr_i = 32'h20; sb.push_back('{mem(32'h20), 1'b0});
         end
         @(negedge clk);
         total++;
         if (stall_o !== (c < 8)) begin bad++; $display("FAIL bp_stall c=%0d got %b want %b", c, stall_o, c < 8); end
         total++;
         if (m_arvalid !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL bp_arvalid c=%0d got %b", c, m_arvalid); end
         total++;
         if (m_rready !== (c >= 5 && c <= 7)) begin bad++; $display("FAIL bp_rready c=%0d got %b", c, m_rready); end
         total++;
         if (rvalid_o !== (c == 8)) begin bad++; $display("FAIL bp_rvalid c=%0d got %b want %b", c, rvalid_o, c == 8); end
         if (c >= 1 && c <= 4) begin
            total++;
            if (m_araddr !== 32'h20) begin bad++; $display("FAIL bp_araddr c=%0d got %h want 00000020", c, m_araddr); end
         end
      end
      @(posedge clk); #1 req_i = 1'b0;
      ar_delay = 0; r_delay = 0;
   endtask

   task automatic wait_rvalid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (rvalid_o) ok = 1'b1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL timeout rvalid_o got 0 want 1 within %0d cycles", max);
      end
   endtask

   task automatic test_error;
      bit ok;
      @(posedge clk); #1;
      req_i = 1'b1; addr_i = 32'h100; sb.push_back('{32'h0, 1'b1});
      wait_rvalid(10, ok);
      if (ok) begin
         total++;
         if (err_o !== 1'b1 || rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL err_resp got err=%b rd=%h want err=1 rd=00000000", err_o, rdata_o);
         end
      end
      @(posedge clk); #1 req_i = 1'b0;
   endtask

   task automatic test_redirect;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin req_i = 1'b1; addr_i = 32'h10; end
         if (c == 2) begin addr_i = 32'h40; sb.push_back('{mem(32'h40), 1'b0}); end
         @(negedge clk);
         total++;
         if (rvalid_o !== (c == 7)) begin bad++; $display("FAIL rd_rvalid c=%0d got %b want %b", c, rvalid_o, c == 7); end
         if (c == 3) begin
            total++;
            if (stall_o !== 1'b1) begin bad++; $display("FAIL rd_stall got %b want 1", stall_o); end
         end
         if (c == 5) begin
            total++;
            if (m_arvalid !== 1'b1 || m_araddr !== 32'h40) begin
               bad++;
               $display("FAIL rd_refetch got arv=%b ara=%h want 1/00000040", m_arvalid, m_araddr);
            end
         end
      end
      @(posedge clk); #1 req_i = 1'b0;
   endtask

   task automatic test_async_reset;
      ar_delay = 5;
      @(posedge clk); #1;
      req_i = 1'b1; addr_i = 32'h8;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (m_arvalid !== 1'b1) begin bad++; $display("FAIL ar_pre got %b want 1", m_arvalid); end
      #2 rst = 1'b0;
      #1;
      total++;
      if (m_arvalid !== 1'b0 || m_rready !== 1'b0 || m_araddr !== 32'h0 || rvalid_o !== 1'b0) begin
         bad++;
         $display("FAIL ar_async got arv=%b rr=%b ara=%h rv=%b want 0/0/0/0", m_arvalid, m_rready, m_araddr, rvalid_o);
      end
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL ar_stall got %b want 1", stall_o); end
      req_i = 1'b0;
      ar_delay = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      test_zero_wait();
   endtask

   task automatic test_back_to_back;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c % 4 == 0) begin
            req_i = 1'b1; addr_i = 32'(c); sb.push_back('{mem(32'(c)), 1'b0});
         end
         @(negedge clk);
         total++;
         if (rvalid_o !== (c % 4 == 3)) begin bad++; $display("FAIL b2b_rvalid c=%0d got %b want %b", c, rvalid_o, c % 4 == 3); end
      end
      @(posedge clk); #1 req_i = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req_i = 1'b0; addr_i = '0;
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_error();
      test_redirect();
      test_async_reset();
      test_back_to_back();
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
